controller_port_array: RTL and testbench

- Parametrised NES/SNES-style serial controller emulator. Maps up to NUM_KEYS concurrent USB HID keycodes onto NUM_PORTS virtual pads of NUM_BUTTONS buttons each.
- Each pad has a strobe-latched shift register read one bit per CPU access.
- Adds per-pad turbo (autofire) on buttons A/B, saturating bit counters and a sticky over-read flag.
- Sits between the USB keycode PIO and the CPU I/O decode for 0x4016/0x4017.

---
 rtl/controller_port_array.sv | 102 ++++++++++
 tb/tb_controller_port_array.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_port_array.sv
// rtl/controller_port_array.sv - NES/SNES serial pad emulator fed from USB HID keycodes
// Keycodes decode to per-pad buttons, get turbo-gated, then strobe-latch into shift registers read one bit per access.
module controller_port_array #(
    parameter int NUM_PORTS   = 2,
    parameter int NUM_BUTTONS = 8,
    parameter int NUM_KEYS    = 6,
    parameter logic [NUM_PORTS*NUM_BUTTONS*8-1:0] KEYMAP = {
        8'd79, 8'd80, 8'd81, 8'd82, 8'd0,  8'd0,  8'd51, 8'd52,
        8'd7,  8'd4,  8'd22, 8'd26, 8'd5,  8'd25, 8'd9,  8'd10
    },
    parameter int   TURBO_DIV  = 4,
    parameter logic FILL_VALUE = 1'b1
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_KEYS-1:0][7:0]                        usb_keycode,
    input  logic                                            strobe,
    input  logic [NUM_PORTS-1:0]                            shift,
    input  logic                                            frame_tick,
    input  logic [NUM_PORTS-1:0][1:0]                       turbo_en,
    output logic [NUM_PORTS-1:0]                            serial_out,
    output logic [NUM_PORTS-1:0][NUM_BUTTONS-1:0]           buttons_q,
    output logic [NUM_PORTS-1:0][$clog2(NUM_BUTTONS+1)-1:0] bit_count,
    output logic [NUM_PORTS-1:0]                            overrun
);
    localparam int CW = $clog2(NUM_BUTTONS + 1);
    localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam int B1 = (NUM_BUTTONS > 1) ? 1 : 0;

    logic [NUM_PORTS-1:0][NUM_BUTTONS-1:0] pressed;
    logic [NUM_PORTS-1:0][NUM_BUTTONS-1:0] eff;
    logic [NUM_PORTS-1:0][NUM_BUTTONS-1:0] shreg;
    logic [NUM_PORTS-1:0][NUM_BUTTONS-1:0] shifted;
    logic [TW-1:0]                         turbo_cnt;
    logic                                  turbo_phase;

    // Keycode 0 means "no key" in the report, so unmapped entries must never match it.
    always_comb begin
        pressed = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (KEYMAP[(p*NUM_BUTTONS+b)*8 +: 8] != 8'd0 &&
                        usb_keycode[i] == KEYMAP[(p*NUM_BUTTONS+b)*8 +: 8]) begin
                        pressed[p][b] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        eff     = buttons_q;
        shifted = '0;
        serial_out = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eff[p][0] = buttons_q[p][0] & (~turbo_en[p][0] | turbo_phase);
            if (NUM_BUTTONS > 1) begin
                eff[p][B1] = buttons_q[p][B1] & (~turbo_en[p][1] | turbo_phase);
            end
            shifted[p]                = shreg[p] >> 1;
            shifted[p][NUM_BUTTONS-1] = FILL_VALUE;
            serial_out[p]             = shreg[p][0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            buttons_q   <= '0;
            bit_count   <= '0;
            overrun     <= '0;
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else begin
            buttons_q <= pressed;
            if (frame_tick) begin
                if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
                    turbo_cnt   <= '0;
                    turbo_phase <= ~turbo_phase;
                end else begin
                    turbo_cnt <= turbo_cnt + 1'b1;
                end
            end
            // Strobe high keeps reloading, so a shift in the same cycle is lost.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (strobe) begin
                    shreg[p]     <= eff[p];
                    bit_count[p] <= '0;
                    overrun[p]   <= 1'b0;
                end else if (shift[p]) begin
                    shreg[p] <= shifted[p];
                    if (bit_count[p] == CW'(NUM_BUTTONS)) begin
                        overrun[p] <= 1'b1;
                    end else begin
                        bit_count[p] <= bit_count[p] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_controller_port_array.sv
// tb/tb_controller_port_array.sv - self-checking bench for controller_port_array
module tb_controller_port_array;
    localparam logic [255:0] KM16 = 256'd44 << 96;

    logic             clock = 1'b0;
    logic             reset;
    logic [5:0][7:0]  usb_keycode;
    logic             strobe;
    logic [1:0]       shift;
    logic [1:0]       shift16;
    logic             frame_tick;
    logic [1:0][1:0]  turbo_en;
    logic [1:0]       serial_out;
    logic [1:0][7:0]  buttons_q;
    logic [1:0][3:0]  bit_count;
    logic [1:0]       overrun;
    logic [1:0]       serial16;
    logic [1:0][15:0] bq16;
    logic [1:0][4:0]  bc16;
    logic [1:0]       ov16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    controller_port_array dut (
        .clock(clock), .reset(reset), .usb_keycode(usb_keycode), .strobe(strobe),
        .shift(shift), .frame_tick(frame_tick), .turbo_en(turbo_en),
        .serial_out(serial_out), .buttons_q(buttons_q), .bit_count(bit_count),
        .overrun(overrun)
    );

    controller_port_array #(.NUM_BUTTONS(16), .KEYMAP(KM16)) dut16 (
        .clock(clock), .reset(reset), .usb_keycode(usb_keycode), .strobe(strobe),
        .shift(shift16), .frame_tick(frame_tick), .turbo_en(turbo_en),
        .serial_out(serial16), .buttons_q(bq16), .bit_count(bc16), .overrun(ov16)
    );

    typedef struct {
        logic       st;
        logic [1:0] sh;
        logic [1:0] so;
        logic [7:0] bq0;
        logic [3:0] bc0;
        logic [1:0] ov;
    } vec_t;
    vec_t tbl[14];

    // Reference model: a pad read is "latched word + number of reads so far".
    int         km[2][8];
    logic [7:0] m_bq[2];
    logic [7:0] m_lat[2];
    int         m_reads[2];
    int         m_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] m_pressed(int p);
        logic [7:0] r = '0;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 6; i++)
                if (km[p][b] != 0 && int'(usb_keycode[i]) == km[p][b]) r[b] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            m_bq[p] = '0; m_lat[p] = '0; m_reads[p] = 0;
        end
        m_frames = 0;
    endtask

    task automatic m_step();
        logic       phase;
        logic [7:0] e;
        phase = ((m_frames / 4) % 2) == 1;
        for (int p = 0; p < 2; p++) begin
            e = m_bq[p];
            if (turbo_en[p][0] && !phase) e[0] = 1'b0;
            if (turbo_en[p][1] && !phase) e[1] = 1'b0;
            if (strobe) begin
                m_lat[p] = e; m_reads[p] = 0;
            end else if (shift[p] && m_reads[p] < 100) begin
                m_reads[p]++;
            end
            m_bq[p] = m_pressed(p);
        end
        if (frame_tick) m_frames++;
    endtask

    task automatic m_compare(input int n);
        logic so;
        for (int p = 0; p < 2; p++) begin
            so = (m_reads[p] < 8) ? m_lat[p][m_reads[p]] : 1'b1;
            chk($sformatf("rnd%0d_so%0d", n, p), 32'(serial_out[p]), 32'(so));
            chk($sformatf("rnd%0d_bq%0d", n, p), 32'(buttons_q[p]), 32'(m_bq[p]));
            chk($sformatf("rnd%0d_bc%0d", n, p), 32'(bit_count[p]),
                32'((m_reads[p] > 8) ? 8 : m_reads[p]));
            chk($sformatf("rnd%0d_ov%0d", n, p), 32'(overrun[p]), 32'(m_reads[p] > 8));
        end
    endtask

    initial begin
        km = '{'{10, 9, 25, 5, 26, 22, 4, 7}, '{52, 51, 0, 0, 82, 81, 80, 79}};
        reset = 1'b1; usb_keycode = '0; strobe = 1'b0; shift = '0; shift16 = '0;
        frame_tick = 1'b0; turbo_en = '0;
        cycle(); cycle();
        chk("rst_so", 32'(serial_out), 0);
        chk("rst_bq", 32'(buttons_q), 0);
        chk("rst_bc", 32'(bit_count), 0);
        chk("rst_ov", 32'(overrun), 0);
        reset = 1'b0;

        // Keys 10 (A) and 7 (Right) on pad 0: latch, strobe+shift collision, 9 reads, re-strobe.
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 8'h81, 4'd0, 2'b00};
        tbl[1]  = '{1'b1, 2'b00, 2'b01, 8'h81, 4'd0, 2'b00};
        tbl[2]  = '{1'b1, 2'b01, 2'b01, 8'h81, 4'd0, 2'b00};
        tbl[3]  = '{1'b0, 2'b00, 2'b01, 8'h81, 4'd0, 2'b00};
        tbl[4]  = '{1'b0, 2'b01, 2'b00, 8'h81, 4'd1, 2'b00};
        tbl[5]  = '{1'b0, 2'b01, 2'b00, 8'h81, 4'd2, 2'b00};
        tbl[6]  = '{1'b0, 2'b01, 2'b00, 8'h81, 4'd3, 2'b00};
        tbl[7]  = '{1'b0, 2'b01, 2'b00, 8'h81, 4'd4, 2'b00};
        tbl[8]  = '{1'b0, 2'b01, 2'b00, 8'h81, 4'd5, 2'b00};
        tbl[9]  = '{1'b0, 2'b01, 2'b00, 8'h81, 4'd6, 2'b00};
        tbl[10] = '{1'b0, 2'b01, 2'b01, 8'h81, 4'd7, 2'b00};
        tbl[11] = '{1'b0, 2'b01, 2'b01, 8'h81, 4'd8, 2'b00};
        tbl[12] = '{1'b0, 2'b01, 2'b01, 8'h81, 4'd8, 2'b01};
        tbl[13] = '{1'b1, 2'b00, 2'b01, 8'h81, 4'd0, 2'b00};
        usb_keycode[0] = 8'd10; usb_keycode[1] = 8'd7;
        for (int i = 0; i < 14; i++) begin
            strobe = tbl[i].st; shift = tbl[i].sh;
            cycle();
            chk($sformatf("tbl%0d_so", i), 32'(serial_out), 32'(tbl[i].so));
            chk($sformatf("tbl%0d_bq0", i), 32'(buttons_q[0]), 32'(tbl[i].bq0));
            chk($sformatf("tbl%0d_bc0", i), 32'(bit_count[0]), 32'(tbl[i].bc0));
            chk($sformatf("tbl%0d_ov", i), 32'(overrun), 32'(tbl[i].ov));
        end

        // Pad 1 over-read with no keys: saturation, sticky overrun, strobe clears.
        usb_keycode = '0; strobe = 1'b1; shift = '0;
        cycle(); cycle();
        strobe = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            shift = 2'b10;
            cycle();
            chk($sformatf("ovr%0d_bc1", k), 32'(bit_count[1]), 32'((k > 8) ? 8 : k));
            chk($sformatf("ovr%0d_ov1", k), 32'(overrun[1]), 32'(k > 8));
            chk($sformatf("ovr%0d_so1", k), 32'(serial_out[1]), 32'(k >= 8));
        end
        shift = '0; strobe = 1'b1;
        cycle();
        chk("ovr_clr_ov1", 32'(overrun[1]), 0);
        chk("ovr_clr_bc1", 32'(bit_count[1]), 0);

        // Turbo on A of pad 0 with A and B held; phase flips every 4 frame ticks.
        strobe = 1'b0; usb_keycode[0] = 8'd10; usb_keycode[1] = 8'd9; turbo_en[0] = 2'b01;
        cycle();
        for (int t = 0; t < 12; t++) begin
            strobe = 1'b1;
            cycle();
            chk($sformatf("turbo%0d_a", t), 32'(serial_out[0]), 32'(t >= 4 && t < 8));
            strobe = 1'b0; shift = 2'b01;
            cycle();
            chk($sformatf("turbo%0d_b", t), 32'(serial_out[0]), 1);
            shift = '0; frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
        end

        // Strobe and shift together with only B held.
        turbo_en = '0; usb_keycode = '0; usb_keycode[0] = 8'd9; strobe = 1'b1;
        cycle(); cycle();
        strobe = 1'b0; shift = 2'b01;
        cycle();
        chk("coll_pre_so0", 32'(serial_out[0]), 1);
        chk("coll_pre_bc0", 32'(bit_count[0]), 1);
        strobe = 1'b1;
        cycle();
        chk("coll_so0", 32'(serial_out[0]), 0);
        chk("coll_bc0", 32'(bit_count[0]), 0);

        // Async reset mid-read; turbo phase was 1 before and must restart at 0.
        shift = '0; turbo_en[0] = 2'b01; usb_keycode[0] = 8'd10; usb_keycode[1] = 8'd52;
        cycle(); cycle();
        chk("prerst_so", 32'(serial_out), 32'(2'b11));
        strobe = 1'b0; shift = 2'b11;
        cycle(); cycle(); cycle();
        shift = '0;
        reset = 1'b1;
        #1;
        chk("arst_so", 32'(serial_out), 0);
        chk("arst_bc", 32'(bit_count), 0);
        chk("arst_bq", 32'(buttons_q), 0);
        #2 reset = 1'b0;
        strobe = 1'b1;
        cycle();
        chk("postrst1_so", 32'(serial_out), 0);
        cycle();
        chk("postrst2_so", 32'(serial_out), 32'(2'b10));

        // 16-button build: key 44 on button 12 of pad 0.
        usb_keycode = '0; usb_keycode[3] = 8'd44; turbo_en = '0;
        cycle(); cycle();
        strobe = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("snes_read%0d", k), 32'(serial16[0]), 32'(k == 12 || k >= 16));
            shift16 = 2'b01;
            cycle();
            shift16 = '0;
        end
        chk("snes_bc", 32'(bc16[0]), 16);
        chk("snes_ov", 32'(ov16[0]), 1);

        // Randomized run against the reference model, with occasional async resets.
        reset = 1'b1; #1; reset = 1'b0;
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0: usb_keycode[i] = 8'd0;
                        3: usb_keycode[i] = 8'($urandom_range(0, 255));
                        default: usb_keycode[i] = 8'(km[$urandom_range(0, 1)][$urandom_range(0, 7)]);
                    endcase
                end
            end
            strobe = ($urandom_range(0, 9) == 0);
            shift = 2'($urandom_range(0, 3));
            frame_tick = ($urandom_range(0, 2) == 0);
            if (n % 16 == 0) turbo_en = 4'($urandom_range(0, 15));
            cycle();
            m_step();
            m_compare(n);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk($sformatf("rnd%0d_arst", n), 32'({serial_out, bit_count, overrun}), 0);
                reset = 1'b0;
                m_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
